// File: rtl/apb_ctrl_pkg.sv
// rtl/apb_ctrl_pkg.sv - shared FSM states, slave count and select decoder for the APB master
package apb_ctrl_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SETUP  = 2'd1,
      ACCESS = 2'd2
   } apb_state_e;

   localparam int APB_NUM_SLAVES = 8;

   // One-hot slave select from a 3-bit slave index.
   function automatic logic [APB_NUM_SLAVES-1:0] apb_slave_dec(input logic [2:0] idx);
      logic [APB_NUM_SLAVES-1:0] sel;
      sel      = '0;
      sel[idx] = 1'b1;
      return sel;
   endfunction

endpackage

// File: rtl/apb_rr_arbiter.sv
// rtl/apb_rr_arbiter.sv - round-robin requester arbiter with pointer advanced on accept
module apb_rr_arbiter #(
   parameter int NUM_REQ = 2,
   parameter int IDX_W   = 1
) (
   input  logic               clk_i,
   input  logic               rst_ni,
   input  logic [NUM_REQ-1:0] req_i,
   input  logic               accept_i,
   output logic [NUM_REQ-1:0] gnt_o,
   output logic [IDX_W-1:0]   gnt_idx_o
);

   logic [IDX_W-1:0] ptr_q, ptr_d;

   // First asserted request at or after the pointer wins, wrapping around.
   always_comb begin
      int   j;
      logic found;
      j         = 0;
      found     = 1'b0;
      gnt_o     = '0;
      gnt_idx_o = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         j = int'(ptr_q) + k;
         if (j >= NUM_REQ) j = j - NUM_REQ;
         if (!found && req_i[j]) begin
            found     = 1'b1;
            gnt_o[j]  = 1'b1;
            gnt_idx_o = IDX_W'(j);
         end
      end
   end

   // After an accepted grant the pointer moves just past the winner.
   always_comb begin
      int nxt;
      nxt = int'(gnt_idx_o) + 1;
      if (nxt >= NUM_REQ) nxt = 0;
      ptr_d = accept_i ? IDX_W'(nxt) : ptr_q;
   end

   // Pointer register; restarts at requester 0.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) ptr_q <= '0;
      else         ptr_q <= ptr_d;
   end

endmodule

// File: rtl/apb_master_arbiter.sv
// rtl/apb_master_arbiter.sv - multi-requester APB master, optional ACCESS timeout via APB_TIMEOUT_EN
module apb_master_arbiter
   import apb_ctrl_pkg::*;
#(
   parameter int ADDR_WIDTH     = 32,
   parameter int DATA_WIDTH     = 32,
   parameter int NUM_REQ        = 2,
   parameter int SEL_LSB        = 12,
   parameter int TIMEOUT_CYCLES = 16
) (
   input  logic                          pclk,
   input  logic                          presetn,
   input  logic [NUM_REQ-1:0]            req_valid,
   output logic [NUM_REQ-1:0]            req_ready,
   input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
   input  logic [NUM_REQ-1:0]            req_write,
   input  logic [NUM_REQ*DATA_WIDTH-1:0] req_wdata,
   output logic [NUM_REQ-1:0]            rsp_valid,
   output logic [DATA_WIDTH-1:0]         rsp_rdata,
   output logic                          rsp_err,
   output logic [APB_NUM_SLAVES-1:0]     psel,
   output logic [ADDR_WIDTH-1:0]         paddr,
   output logic                          pwrite,
   output logic                          penable,
   output logic [DATA_WIDTH-1:0]         pwdata,
   input  logic [DATA_WIDTH-1:0]         prdata,
   input  logic                          pready,
   input  logic                          pslverr
);

   localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
   localparam logic [1:0] ST_IDLE   = IDLE;
   localparam logic [1:0] ST_SETUP  = SETUP;
   localparam logic [1:0] ST_ACCESS = ACCESS;

   logic [1:0]                state_q, state_d;
   logic [IDX_W-1:0]          gidx_q, arb_idx;
   logic [NUM_REQ-1:0]        arb_gnt, gnt_onehot;
   logic [APB_NUM_SLAVES-1:0] psel_q;
   logic [ADDR_WIDTH-1:0]     paddr_q, win_addr;
   logic [DATA_WIDTH-1:0]     pwdata_q, win_wdata, rsp_rdata_q;
   logic [NUM_REQ-1:0]        rsp_valid_q;
   logic                      pwrite_q, penable_q, rsp_err_q, win_write;
   logic                      hs, done, timeout_hit;

   apb_rr_arbiter #(.NUM_REQ(NUM_REQ), .IDX_W(IDX_W)) u_arb (
      .clk_i     (pclk),
      .rst_ni    (presetn),
      .req_i     (req_valid),
      .accept_i  (hs),
      .gnt_o     (arb_gnt),
      .gnt_idx_o (arb_idx)
   );

   // Only the arbitration winner sees ready, and only while idle and out of reset.
   assign req_ready = (presetn && state_q == ST_IDLE) ? arb_gnt : '0;
   assign hs        = presetn && (state_q == ST_IDLE) && (|req_valid);
   assign done      = (state_q == ST_ACCESS) && (pready || timeout_hit);

   // Select the winning requester's command fields.
   always_comb begin
      win_addr  = '0;
      win_wdata = '0;
      win_write = 1'b0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (arb_gnt[i]) begin
            win_addr  = req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
            win_wdata = req_wdata[i*DATA_WIDTH +: DATA_WIDTH];
            win_write = req_write[i];
         end
      end
   end

   // Completion pulse goes back to the requester that owns the transfer.
   always_comb begin
      gnt_onehot         = '0;
      gnt_onehot[gidx_q] = 1'b1;
   end

`ifdef APB_TIMEOUT_EN
   localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
   logic [CNT_W-1:0] to_cnt_q;

   assign timeout_hit = (state_q == ST_ACCESS) && !pready &&
                        (to_cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

   // Count consecutive pready-low ACCESS cycles; zero in every other state.
   always_ff @(posedge pclk or negedge presetn) begin
      if (!presetn)                                     to_cnt_q <= '0;
      else if (state_q == ST_ACCESS && !pready && !timeout_hit) to_cnt_q <= to_cnt_q + 1'b1;
      else                                              to_cnt_q <= '0;
   end
`else
   logic unused_timeout_cfg;
   assign unused_timeout_cfg = (TIMEOUT_CYCLES == 0);
   assign timeout_hit        = 1'b0;
`endif

   // IDLE -> SETUP on handshake, SETUP -> ACCESS always, ACCESS -> IDLE on completion.
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE:   if (hs)   state_d = ST_SETUP;
         ST_SETUP:            state_d = ST_ACCESS;
         ST_ACCESS: if (done) state_d = ST_IDLE;
         default:             state_d = ST_IDLE;
      endcase
   end

   // APB bus registers and response registers; reset drops any in-flight transfer.
   always_ff @(posedge pclk or negedge presetn) begin
      if (!presetn) begin
         state_q     <= ST_IDLE;
         gidx_q      <= '0;
         psel_q      <= '0;
         paddr_q     <= '0;
         pwrite_q    <= 1'b0;
         penable_q   <= 1'b0;
         pwdata_q    <= '0;
         rsp_valid_q <= '0;
         rsp_rdata_q <= '0;
         rsp_err_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         rsp_valid_q <= '0;
         rsp_rdata_q <= '0;
         rsp_err_q   <= 1'b0;
         if (hs) begin
            gidx_q   <= arb_idx;
            paddr_q  <= win_addr;
            pwrite_q <= win_write;
            psel_q   <= apb_slave_dec(win_addr[SEL_LSB+2:SEL_LSB]);
            if (win_write) pwdata_q <= win_wdata;
         end
         if (state_q == ST_SETUP) penable_q <= 1'b1;
         if (done) begin
            psel_q      <= '0;
            penable_q   <= 1'b0;
            rsp_valid_q <= gnt_onehot;
            rsp_rdata_q <= (pwrite_q || timeout_hit) ? '0 : prdata;
            rsp_err_q   <= timeout_hit ? 1'b1 : pslverr;
         end
      end
   end

   assign psel      = psel_q;
   assign paddr     = paddr_q;
   assign pwrite    = pwrite_q;
   assign penable   = penable_q;
   assign pwdata    = pwdata_q;
   assign rsp_valid = rsp_valid_q;
   assign rsp_rdata = rsp_rdata_q;
   assign rsp_err   = rsp_err_q;

endmodule

// File: doc/apb_master_arbiter.md
# apb_master_arbiter

Multi-requester APB master for the AXI-to-APB bridge. Arbitrates up to NUM_REQ simple command requesters round-robin and sequences one APB transfer at a time through SETUP and ACCESS phases. Decodes one of 8 slaves onto `psel` and returns read data and error status to the granted requester. Drives the master side of the `apb_if` bus (modport `APB_Master`).

## Interface
Parameters:
- `ADDR_WIDTH`, 32: APB address width.
- `DATA_WIDTH`, 32: APB data width.
- `NUM_REQ`, 2: number of requesters, range 1–8.
- `SEL_LSB`, 12: slave index is `addr[SEL_LSB+2:SEL_LSB]`.
- `TIMEOUT_CYCLES`, 16: ACCESS wait limit; only used with `APB_TIMEOUT_EN`.

Ports:
- `pclk` in 1: single clock for the block.
- `presetn` in 1: reset, asynchronous, active-low.
- `req_valid` in NUM_REQ: per-requester command valid.
- `req_ready` out NUM_REQ: per-requester accept (combinational).
- `req_addr` in NUM_REQ*ADDR_WIDTH: packed, requester i at slice i.
- `req_write` in NUM_REQ: 1 = write.
- `req_wdata` in NUM_REQ*DATA_WIDTH: packed write data.
- `rsp_valid` out NUM_REQ: one-hot, single-cycle completion pulse.
- `rsp_rdata` out DATA_WIDTH: read data, valid with `rsp_valid`.
- `rsp_err` out 1: `pslverr` or timeout, valid with `rsp_valid`.
- `psel` out 8: one-hot slave select.
- `paddr` out ADDR_WIDTH: APB address.
- `pwrite` out 1: APB direction.
- `penable` out 1: APB enable.
- `pwdata` out DATA_WIDTH: APB write data.
- `prdata` in DATA_WIDTH: APB read data.
- `pready` in 1: APB ready.
- `pslverr` in 1: APB slave error.

## Operation
- FSM states are IDLE, SETUP and ACCESS. Reset state is IDLE.
- **IDLE**
  - Round-robin arbiter picks among the asserted `req_valid` bits, starting from pointer `rr_ptr`.
  - `req_ready` is high only for the winner, and only in IDLE.
  - On handshake (`valid` & `ready`): latch addr, write and wdata into output registers; latch the grant index. Next state is SETUP.
  - `rr_ptr` becomes grant+1, modulo NUM_REQ.
- **SETUP**
  - `psel[addr[SEL_LSB+2:SEL_LSB]]` = 1, `penable` = 0, `paddr`/`pwrite`/`pwdata` stable.
  - Next state is ACCESS, unconditionally.
- **ACCESS**
  - `penable` = 1; `psel`/`paddr`/`pwrite`/`pwdata` held.
  - When `pready` = 1: capture `prdata` (reads only; writes return 0) and `pslverr`. Next cycle `rsp_valid[grant]` = 1 with `rsp_rdata`/`rsp_err`.
  - `psel` and `penable` drop to 0; return to IDLE.
- `pwdata` is held from the previous transfer during reads; it is don't-care on the bus.
- Requesters hold addr/write/wdata stable while `req_valid` is high and `req_ready` is low. `req_valid` must not drop before handshake.
- A requester that is not granted keeps waiting. The round-robin guarantees it is granted within NUM_REQ transfers.
- **Reset mid-transfer:** all registers clear immediately and asynchronously. The in-flight transfer is dropped with no `rsp_valid`. `rr_ptr` = 0.

## Timing
- Reset values are 0 for: `psel`, `paddr`, `pwrite`, `penable`, `pwdata`, `rsp_valid`, `rsp_rdata`, `rsp_err`, `req_ready`, `rr_ptr`, grant.
- All APB and rsp outputs are registered. `req_ready` is combinational from `req_valid`, state and `rr_ptr`.
- Zero-wait-state transfer:
  - Handshake in cycle 0.
  - SETUP in cycle 1.
  - ACCESS with `pready` in cycle 2.
  - `rsp_valid` in cycle 3.
- Each `pready`-low cycle in ACCESS adds one cycle.
- Minimum spacing between handshakes is 3 cycles. A new handshake may occur in the same cycle as the previous `rsp_valid`, since the FSM is back in IDLE.

## Configuration
- Macro: `APB_TIMEOUT_EN`.
- **Defined:** a counter runs in ACCESS while `pready` = 0. After TIMEOUT_CYCLES consecutive low cycles the transfer aborts:
  - `psel`/`penable` deassert.
  - `rsp_valid[grant]` pulses with `rsp_err` = 1 and `rsp_rdata` = 0.
  - FSM returns to IDLE.
  - The counter clears on every state entry.
- **Undefined:** no counter; ACCESS waits for `pready` indefinitely.

## Structure
- Package `apb_ctrl_pkg` contains:
  - The `apb_state_e` enum (IDLE/SETUP/ACCESS).
  - `APB_NUM_SLAVES` = 8.
  - Function `apb_slave_dec(idx)`, returning the one-hot 8-bit select.
- Sub-module `apb_rr_arbiter`: NUM_REQ request vector in, one-hot grant plus index out, pointer advanced on an `accept` strobe.
- Top FSM and datapath live in `apb_master_arbiter`.

## Test plan
- **Single write:** req0 writes addr 0x0000_2010, data 0xA5A5_0001, `pready` = 1. Expect:
  - Cycle 1: `psel` = 0x04, `penable` = 0.
  - Cycle 2: `penable` = 1.
  - Cycle 3: `rsp_valid` = 0b01, `rsp_err` = 0.
- **Read with 3 wait states:** req1 reads 0x0000_7000; `pready` low for 3 ACCESS cycles; `prdata` = 0xDEAD_BEEF. Expect:
  - `psel` = 0x80 held for 5 cycles.
  - `rsp_valid` = 0b10, `rsp_rdata` = 0xDEAD_BEEF at cycle 6.
- **Contention:** req0 and req1 held valid continuously from reset. Grants alternate 0,1,0,1. Each `rsp_valid` is one-hot to the granted requester.
- **Slave error:** read with `pslverr` = 1 at `pready`. Expect `rsp_err` = 1 for exactly the one `rsp_valid` cycle.
- **Timeout (`APB_TIMEOUT_EN`, TIMEOUT_CYCLES = 16):** `pready` held low. Expect:
  - After 16 ACCESS cycles, `psel` = 0.
  - `rsp_err` = 1, `rsp_rdata` = 0.
  - The next request is accepted normally.
- **Reset mid-ACCESS:** drop `presetn` during ACCESS. All outputs go to 0 asynchronously and no `rsp_valid` appears. After release, the first grant goes to req0.
